// File: rtl/tool_select_if.sv
// Button, frame-strobe and committed-cursor signals exchanged between the
// button/timing source and the tool selector.
interface tool_select_if;
  logic       btn_color;
  logic       btn_width_up;
  logic       btn_width_dn;
  logic       new_frame;
  logic [3:0] cursor_color;
  logic [2:0] stroke_width;
  logic       changed;

  modport master (
    output btn_color, btn_width_up, btn_width_dn, new_frame,
    input  cursor_color, stroke_width, changed
  );

  modport slave (
    input  btn_color, btn_width_up, btn_width_dn, new_frame,
    output cursor_color, stroke_width, changed
  );
endinterface

// File: rtl/tool_select.sv
// Debounces the colour / width-up / width-down buttons, accumulates edits in
// pending registers and commits them to the sidebar only on frame boundaries.
module tool_select #(
  parameter int unsigned DEBOUNCE_CYCLES = 371250,
  parameter int unsigned NUM_COLORS      = 9,
  parameter int unsigned MIN_WIDTH       = 1,
  parameter int unsigned MAX_WIDTH       = 7,
  parameter int unsigned RESET_COLOR     = 1,
  parameter int unsigned RESET_WIDTH     = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_color_in,
  input  logic       btn_width_up_in,
  input  logic       btn_width_dn_in,
  input  logic       new_frame_in,
  output logic [3:0] cursor_color_out,
  output logic [2:0] stroke_width_out,
  output logic       changed_out
);

  localparam int unsigned CTR_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CTR_W-1:0] CTR_LAST    = CTR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       COLOR_LAST  = 4'(NUM_COLORS - 1);
  localparam logic [3:0]       COLOR_RST   = 4'(RESET_COLOR);
  localparam logic [2:0]       WIDTH_MIN   = 3'(MIN_WIDTH);
  localparam logic [2:0]       WIDTH_MAX   = 3'(MAX_WIDTH);
  localparam logic [2:0]       WIDTH_RST   = 3'(RESET_WIDTH);

  // Bit 0 colour, bit 1 width-up, bit 2 width-down.
  logic [2:0] raw;
  assign raw = {btn_width_dn_in, btn_width_up_in, btn_color_in};

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       stable_q, stable_d;
  logic [2:0]       stable_dly_q, stable_dly_d;
  logic [2:0]       press_q, press_d;
  logic [CTR_W-1:0] ctr_q [3];
  logic [CTR_W-1:0] ctr_d [3];

  logic [3:0] pend_color_q, pend_color_d;
  logic [2:0] pend_width_q, pend_width_d;
  logic [3:0] color_q, color_d;
  logic [2:0] width_q, width_d;
  logic       changed_q, changed_d;

  always_comb begin
    sync1_d      = raw;
    sync2_d      = sync1_q;
    stable_d     = stable_q;
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
    for (int unsigned i = 0; i < 3; i++) begin
      ctr_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (ctr_q[i] == CTR_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          ctr_d[i] = ctr_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pend_color_d = pend_color_q;
    pend_width_d = pend_width_q;
    if (press_q[0]) begin
      pend_color_d = (pend_color_q == COLOR_LAST) ? '0 : pend_color_q + 4'd1;
    end
    // Simultaneous up and down cancel; each direction saturates at its limit.
    unique case (press_q[2:1])
      2'b01:   if (pend_width_q < WIDTH_MAX) pend_width_d = pend_width_q + 3'd1;
      2'b10:   if (pend_width_q > WIDTH_MIN) pend_width_d = pend_width_q - 3'd1;
      default: pend_width_d = pend_width_q;
    endcase
  end

  // Commit samples the pending registers as they stood before this edge, so
  // an edit landing on the frame cycle waits for the next frame.
  always_comb begin
    color_d   = color_q;
    width_d   = width_q;
    changed_d = 1'b0;
    if (new_frame_in) begin
      color_d   = pend_color_q;
      width_d   = pend_width_q;
      changed_d = (pend_color_q != color_q) || (pend_width_q != width_q);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stable_dly_q <= '0;
      press_q      <= '0;
      for (int unsigned i = 0; i < 3; i++) ctr_q[i] <= '0;
      pend_color_q <= COLOR_RST;
      pend_width_q <= WIDTH_RST;
      color_q      <= COLOR_RST;
      width_q      <= WIDTH_RST;
      changed_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      press_q      <= press_d;
      for (int unsigned i = 0; i < 3; i++) ctr_q[i] <= ctr_d[i];
      pend_color_q <= pend_color_d;
      pend_width_q <= pend_width_d;
      color_q      <= color_d;
      width_q      <= width_d;
      changed_q    <= changed_d;
    end
  end

  assign cursor_color_out = color_q;
  assign stroke_width_out = width_q;
  assign changed_out      = changed_q;

endmodule

// File: tb/tb_tool_select.sv
// Directed bench for tool_select with a 4-cycle debounce window.
module tb_tool_select;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tool_select_if ifc ();

  always #5 clk = ~clk;

  tool_select #(
    .DEBOUNCE_CYCLES(4),
    .NUM_COLORS(9),
    .MIN_WIDTH(1),
    .MAX_WIDTH(7),
    .RESET_COLOR(1),
    .RESET_WIDTH(1)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .btn_color_in(ifc.btn_color),
    .btn_width_up_in(ifc.btn_width_up),
    .btn_width_dn_in(ifc.btn_width_dn),
    .new_frame_in(ifc.new_frame),
    .cursor_color_out(ifc.cursor_color),
    .stroke_width_out(ifc.stroke_width),
    .changed_out(ifc.changed)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input int c, input int w, input int chg);
    check({tag, "_color"}, 32'(ifc.cursor_color), 32'(c));
    check({tag, "_width"}, 32'(ifc.stroke_width), 32'(w));
    check({tag, "_changed"}, 32'(ifc.changed), 32'(chg));
  endtask

  // One-cycle frame strobe; outputs and changed are visible the cycle after.
  task automatic commit(input string tag, input int c, input int w, input int chg);
    ifc.new_frame = 1'b1;
    tick(1);
    ifc.new_frame = 1'b0;
    check_out(tag, c, w, chg);
    tick(1);
    check({tag, "_pulse_end"}, 32'(ifc.changed), 32'd0);
  endtask

  // mask bit 0 colour, bit 1 up, bit 2 down; hold then release and let settle.
  task automatic press(input logic [2:0] mask, input int hold);
    {ifc.btn_width_dn, ifc.btn_width_up, ifc.btn_color} = mask;
    tick(hold);
    {ifc.btn_width_dn, ifc.btn_width_up, ifc.btn_color} = 3'b000;
    tick(12);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    ifc.btn_color = 1'b0;
    ifc.btn_width_up = 1'b0;
    ifc.btn_width_dn = 1'b0;
    ifc.new_frame = 1'b0;
    tick(1);
    do_reset();
    check_out("reset", 1, 1, 0);
    commit("first_frame", 1, 1, 0);

    press(3'b001, 20);
    check_out("no_frame_hold", 1, 1, 0);
    commit("color_press", 2, 1, 1);

    // Bounces of 1..3 cycles must not register.
    for (int len = 1; len <= 3; len++) begin
      ifc.btn_width_up = 1'b1;
      tick(len);
      ifc.btn_width_up = 1'b0;
      tick(3);
    end
    tick(10);
    commit("bounce_only", 2, 1, 0);
    press(3'b010, 20);
    commit("bounce_then_press", 2, 2, 1);

    do_reset();
    check_out("reset2", 1, 1, 0);
    for (int i = 0; i < 8; i++) press(3'b001, 20);
    commit("color_wrap", 0, 1, 1);
    for (int i = 0; i < 10; i++) press(3'b010, 20);
    commit("width_sat_max", 0, 7, 1);
    for (int i = 0; i < 10; i++) press(3'b100, 20);
    commit("width_sat_min", 0, 1, 1);

    press(3'b010, 20);
    commit("width_up", 0, 2, 1);
    press(3'b110, 20);
    commit("up_dn_cancel", 0, 2, 0);
    press(3'b011, 20);
    commit("color_and_up", 1, 3, 1);

    press(3'b001, 20);
    press(3'b010, 20);
    tick(5);
    check_out("two_presses_no_frame", 1, 3, 0);
    commit("two_presses_commit", 2, 4, 1);

    // Reset in the middle of a debounce discards both the button and pending.
    press(3'b001, 20);
    ifc.btn_color = 1'b1;
    tick(4);
    rst = 1'b1;
    ifc.btn_color = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(20);
    check_out("mid_debounce_reset", 1, 1, 0);
    commit("mid_debounce_commit", 1, 1, 0);

    // A button held across reset release counts once.
    ifc.btn_color = 1'b1;
    do_reset();
    tick(20);
    ifc.btn_color = 1'b0;
    tick(12);
    commit("held_through_reset", 2, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
